// File: rtl/cla_pipe_pkg.sv
// rtl/cla_pipe_pkg.sv - shared types, op encoding and geometry helpers for the pipelined CLA adder
package cla_pipe_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic int group_count(input int width, input int stages, input int group);
        return width / (stages * group);
    endfunction

    // Per-stage control bits: valid flag and the carry leaving this stage's slice.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    // Result flags registered with the final stage.
    typedef struct packed {
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - GROUP-bit carry-lookahead cell with group generate/propagate
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic             cin,
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    output logic [GROUP-1:0] sum,
    output logic             cout,
    output logic             g,
    output logic             p
);

    logic [GROUP-1:0] gen;
    logic [GROUP-1:0] prop;
    logic [GROUP:0]   carry;
    logic             acc;
    logic             term;
    logic             g_acc;
    logic             g_term;
    logic             p_acc;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Every bit carry as a flat sum of products of generate/propagate and cin.
    always_comb begin
        acc   = 1'b0;
        term  = 1'b0;
        carry = '0;
        for (int i = 0; i <= GROUP; i++) begin
            term = cin;
            for (int j = 0; j < i; j++) begin
                term = term & prop[j];
            end
            acc = term;
            for (int j = 0; j < i; j++) begin
                term = gen[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & prop[k];
                end
                acc = acc | term;
            end
            carry[i] = acc;
        end
    end

    // Group generate/propagate, independent of cin, for the next lookahead level.
    always_comb begin
        g_acc  = 1'b0;
        g_term = 1'b0;
        p_acc  = 1'b1;
        for (int j = 0; j < GROUP; j++) begin
            g_term = gen[j];
            for (int k = j + 1; k < GROUP; k++) begin
                g_term = g_term & prop[k];
            end
            g_acc = g_acc | g_term;
            p_acc = p_acc & prop[j];
        end
    end

    assign sum  = prop ^ carry[GROUP-1:0];
    assign cout = carry[GROUP];
    assign g    = g_acc;
    assign p    = p_acc;

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead add/sub with valid/ready; flags via CLA_PIPE_FLAGS_EN
module cla_pipe_adder
    import cla_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int SLICE   = slice_width(WIDTH, STAGES);
    localparam int NGROUPS = group_count(WIDTH, STAGES, GROUP);
    localparam int LAST    = STAGES - 1;

    // Operands feeding stage s, shifted so slice s always sits in the low SLICE bits.
    // b is already inverted for subtract.
    logic [WIDTH-1:0] a_src   [STAGES];
    logic [WIDTH-1:0] b_src   [STAGES];
    // Index s is the input of stage s; index STAGES is the output of the last stage.
    logic             v_src   [STAGES+1];
    logic             c_src   [STAGES+1];
    logic [WIDTH-1:0] sum_src [STAGES+1];
    // Partial sum including slice s, as captured into stage s.
    logic [WIDTH-1:0] sum_nxt [STAGES];

    logic adv;

    // The whole pipe moves together; it only stalls when a result sits unconsumed.
    assign adv      = out_ready | ~v_src[STAGES];
    assign in_ready = adv;

    assign a_src[0]   = in_a;
    assign b_src[0]   = (in_sub == OP_SUB) ? ~in_b : in_b;
    assign c_src[0]   = (in_sub == OP_SUB) ? ~in_cin : in_cin;
    assign v_src[0]   = in_valid & adv;
    assign sum_src[0] = '0;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [SLICE-1:0]   op_a;
        logic [SLICE-1:0]   op_b;
        logic [SLICE-1:0]   slice_sum;
        logic [NGROUPS-1:0] gcarry;
        logic [NGROUPS-1:0] grp_g;
        logic [NGROUPS-1:0] grp_p;
        logic [NGROUPS-1:0] grp_cout;
        logic               unused_ripple_cout;
        logic               slice_g;
        logic               slice_p;
        logic               slice_cout;
        logic [WIDTH-1:0]   slice_ext;
        stage_ctl_t         ctl_q;
        logic [WIDTH-1:0]   sum_q;

        assign op_a      = a_src[s][SLICE-1:0];
        assign op_b      = b_src[s][SLICE-1:0];
        assign gcarry[0] = c_src[s];

        for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
            cla_group #(
                .GROUP(GROUP)
            ) u_grp (
                .cin  (gcarry[k]),
                .a    (op_a[k*GROUP +: GROUP]),
                .b    (op_b[k*GROUP +: GROUP]),
                .sum  (slice_sum[k*GROUP +: GROUP]),
                .cout (grp_cout[k]),
                .g    (grp_g[k]),
                .p    (grp_p[k])
            );
            if (k < NGROUPS - 1) begin : g_ripple
                assign gcarry[k+1] = grp_cout[k];
            end else begin : g_top
                // Slice carry-out comes from the group G/P lookahead below instead.
                assign unused_ripple_cout = grp_cout[k];
            end
        end

        // Slice carry-out from group generate/propagate, so the register input
        // does not wait on the group ripple.
        always_comb begin
            slice_g = 1'b0;
            slice_p = 1'b1;
            for (int k = 0; k < NGROUPS; k++) begin
                slice_g = grp_g[k] | (grp_p[k] & slice_g);
                slice_p = slice_p & grp_p[k];
            end
            slice_cout = slice_g | (slice_p & c_src[s]);
        end

        // Place this slice's sum bits at their final position in the result.
        always_comb begin
            slice_ext = '0;
            slice_ext[s*SLICE +: SLICE] = slice_sum;
        end

        assign sum_nxt[s] = sum_src[s] | slice_ext;

        // Stage register: valid, slice carry and accumulated sum bits.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ctl_q <= '0;
                sum_q <= '0;
            end else if (adv) begin
                ctl_q.valid <= v_src[s];
                ctl_q.carry <= slice_cout;
                sum_q       <= sum_nxt[s];
            end
        end

        assign v_src[s+1]   = ctl_q.valid;
        assign c_src[s+1]   = ctl_q.carry;
        assign sum_src[s+1] = sum_q;

        if (s < STAGES - 1) begin : g_rem
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // Carry the not-yet-added operand bits forward, dropping the consumed slice.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src[s] >> SLICE;
                    b_q <= b_src[s] >> SLICE;
                end
            end

            assign a_src[s+1] = a_q;
            assign b_src[s+1] = b_q;
        end
    end

    assign out_valid = v_src[STAGES];
    assign out_sum   = sum_src[STAGES];
    assign out_cout  = c_src[STAGES];

`ifdef CLA_PIPE_FLAGS_EN
    flags_t flags_q;

    // Flags use the top slice operands still present in the last stage, so no
    // separate msb pipeline is needed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (adv) begin
            flags_q.ovf  <= (a_src[LAST][SLICE-1] == b_src[LAST][SLICE-1]) &
                            (sum_nxt[LAST][WIDTH-1] != a_src[LAST][SLICE-1]);
            flags_q.zero <= ~|sum_nxt[LAST];
            flags_q.neg  <= sum_nxt[LAST][WIDTH-1];
        end
    end

    assign out_ovf  = flags_q.ovf;
    assign out_zero = flags_q.zero;
    assign out_neg  = flags_q.neg;
`else
    assign out_ovf  = 1'b0;
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder
module tb_cla_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int GROUP  = 4;
    localparam int STAGES = 2;
`ifdef CLA_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif
    localparam longint SMAX = (64'sd1 <<< 31) - 64'sd1;
    localparam longint SMIN = -(64'sd1 <<< 31);

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic        out_neg;

    logic        w_valid;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic        d1_in_ready, d1_out_valid, d1_cout, d1_ovf, d1_zero, d1_neg;
    logic [63:0] d1_sum;
    logic        d4_in_ready, d4_out_valid, d4_cout, d4_ovf, d4_zero, d4_neg;
    logic [63:0] d4_sum;

    int checks = 0;
    int errors = 0;
    res_t        exp_q[$];
    logic [31:0] got_q[$];

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg)
    );

    cla_pipe_adder #(.WIDTH(64), .GROUP(4), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(d1_in_ready),
        .in_a(w_a), .in_b(w_b), .in_cin(1'b0), .in_sub(1'b0),
        .out_valid(d1_out_valid), .out_ready(1'b1), .out_sum(d1_sum),
        .out_cout(d1_cout), .out_ovf(d1_ovf), .out_zero(d1_zero), .out_neg(d1_neg)
    );

    cla_pipe_adder #(.WIDTH(64), .GROUP(4), .STAGES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(d4_in_ready),
        .in_a(w_a), .in_b(w_b), .in_cin(1'b0), .in_sub(1'b0),
        .out_valid(d4_out_valid), .out_ready(1'b1), .out_sum(d4_sum),
        .out_cout(d4_cout), .out_ovf(d4_ovf), .out_zero(d4_zero), .out_neg(d4_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: plain wide arithmetic; signed overflow from the true signed result.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        res_t r;
        logic [32:0] full;
        longint sa, sb, ci, sres;
        sa = $signed(a);
        sb = $signed(b);
        ci = cin ? 64'sd1 : 64'sd0;
        if (!sub) begin
            full   = {1'b0, a} + {1'b0, b} + 33'(cin);
            sres   = sa + sb + ci;
            r.cout = full[32];
        end else begin
            full   = {1'b0, a} - {1'b0, b} - 33'(cin);
            sres   = sa - sb - ci;
            r.cout = ~full[32];
        end
        r.sum  = full[31:0];
        r.ovf  = FLAGS && (sres > SMAX || sres < SMIN);
        r.zero = FLAGS && (r.sum == 32'h0);
        r.neg  = FLAGS && r.sum[31];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic account();
        res_t e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got=%0h expected=none", out_sum);
            end else begin
                e = exp_q.pop_front();
                check("sb_sum",  64'(out_sum),  64'(e.sum));
                check("sb_cout", 64'(out_cout), 64'(e.cout));
                check("sb_ovf",  64'(out_ovf),  64'(e.ovf));
                check("sb_zero", 64'(out_zero), 64'(e.zero));
                check("sb_neg",  64'(out_neg),  64'(e.neg));
                got_q.push_back(out_sum);
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
    endtask

    task automatic step();
        #1;
        account();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs[9];
        logic [31:0] bp_exp[4];
        int          lat, sent, fires, lat1, lat4;
        logic        stalled;
        logic [31:0] held;
        logic [63:0] s1, s4;
        logic        o1, o4;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
        bp_exp  = '{32'd3, 32'd5, 32'd7, 32'd9};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1; w_valid = 1'b0; w_a = '0; w_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_cout",  64'(out_cout),  64'd0);
        check("rst_out_flags", 64'({out_ovf, out_zero, out_neg}), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);

        // Directed table with per-vector latency.
        for (int i = 0; i < 9; i++) begin
            in_a = vecs[i].a; in_b = vecs[i].b; in_cin = vecs[i].cin; in_sub = vecs[i].sub;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                step();
                lat++;
            end
            check("vec_latency", 64'(lat), 64'(STAGES));
            check("vec_sum",  64'(out_sum),  64'(vecs[i].sum));
            check("vec_cout", 64'(out_cout), 64'(vecs[i].cout));
            check("vec_ovf",  64'(out_ovf),  64'(FLAGS & vecs[i].ovf));
            check("vec_zero", 64'(out_zero), 64'(FLAGS & vecs[i].zero));
            check("vec_neg",  64'(out_neg),  64'(FLAGS & vecs[i].neg));
            step();
        end

        // Back-pressure mid-stream.
        got_q.delete();
        sent = 0;
        stalled = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 40 && got_q.size() < 4; cyc++) begin
            in_valid = (sent < 4);
            in_a = 32'(sent + 1); in_b = 32'(sent + 2); in_cin = 1'b0; in_sub = 1'b0;
            out_ready = !(cyc >= 2 && cyc < 5);
            #1;
            if (out_valid && !out_ready) begin
                check("bp_in_ready", 64'(in_ready), 64'd0);
                if (stalled) check("bp_hold", 64'(out_sum), 64'(held));
                held = out_sum;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (in_valid && in_ready) sent++;
            account();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check("bp_order", 64'(got_q[i]), 64'(bp_exp[i]));
        end

        // Full-throughput random stream.
        fires = 0;
        for (int j = 0; j < 100; j++) begin
            in_valid = 1'b1;
            in_a = $urandom; in_b = $urandom;
            in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
            if (j == 10) begin in_a = 32'd5; in_b = 32'd5; in_cin = 1'b1; in_sub = 1'b1; end
            #1;
            if (out_valid) fires++;
            account();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("thr_fires", 64'(fires), 64'(100 - STAGES));
        for (int j = 0; j < 10 && exp_q.size() > 0; j++) step();
        check("thr_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two operations in flight.
        out_ready = 1'b0;
        in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_cin = 1'b0; in_sub = 1'b0;
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_out_sum",   64'(out_sum),   64'd0);
        check("mr_out_cout",  64'(out_cout),  64'd0);
        check("mr_out_flags", 64'({out_ovf, out_zero, out_neg}), 64'd0);
        check("mr_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #1;
            check("mr_no_stale", 64'(out_valid), 64'd0);
            account();
            @(posedge clk);
            #1;
        end

        // 64-bit STAGES=1 and STAGES=4 variants.
        w_a = 64'h7FFF_FFFF_FFFF_FFFF; w_b = 64'h1;
        w_valid = 1'b1;
        step();
        w_valid = 1'b0;
        lat1 = 0; lat4 = 0; s1 = '0; s4 = '0; o1 = 1'b0; o4 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            if (d1_out_valid && lat1 == 0) begin lat1 = e; s1 = d1_sum; o1 = d1_ovf; end
            if (d4_out_valid && lat4 == 0) begin lat4 = e; s4 = d4_sum; o4 = d4_ovf; end
            step();
        end
        check("s1_latency", 64'(lat1), 64'd1);
        check("s1_sum", s1, 64'h8000_0000_0000_0000);
        check("s1_ovf", 64'(o1), 64'(FLAGS));
        check("s4_latency", 64'(lat4), 64'd4);
        check("s4_sum", s4, 64'h8000_0000_0000_0000);
        check("s4_ovf", 64'(o4), 64'(FLAGS));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
